tx_frame_controller: RTL and testbench

Transmit-side frame controller for the UART system. It collects responses from the register file (read data) and the ALU (result), and serialises each into a byte frame. Frames are handed one byte at a time to the UART TX serialiser over a valid/busy handshake. It is the mirror of the receive-side command decoder and shares its clock and reset domain.

---
 rtl/uart_sys_pkg.sv | 22 ++
 rtl/tx_frame_controller_if.sv | 26 ++
 rtl/tx_frame_slot_buf.sv | 107 ++++++++++
 rtl/tx_frame_controller.sv | 123 ++++++++++++
 tb/tb_tx_frame_controller.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_sys_pkg.sv
// Shared UART-system definitions: frame types, TX FSM encoding, header defaults.
// Pure declarations, no logic and no latency.
// Used by the TX frame controller and its slot buffer.
package uart_sys_pkg;

  // Frame type carried alongside each buffered payload
  typedef enum logic {
    FRM_RF  = 1'b0,
    FRM_ALU = 1'b1
  } frm_type_e;

  // TX FSM encoding kept as plain constants for compatibility with older blocks
  localparam logic [1:0] ST_IDLE      = 2'b00;
  localparam logic [1:0] ST_SEND      = 2'b01;
  localparam logic [1:0] ST_WAIT_ACK  = 2'b11;
  localparam logic [1:0] ST_WAIT_DONE = 2'b10;

  // Default header bytes for the optional frame header
  localparam logic [7:0] HDR_RF_DEF  = 8'h5A;
  localparam logic [7:0] HDR_ALU_DEF = 8'hA5;

endpackage

// File: rtl/tx_frame_controller_if.sv
// Response-capture and UART-TX byte handshake bundle of the TX frame controller.
// Wires only, no latency.
// slave = controller side, master = response sources plus UART TX side.
interface tx_frame_controller_if #(
  parameter int ALU_WIDTH = 16
);
  logic [7:0]           TXCont_RF_Rd_Data;
  logic                 TXCont_RF_Rd_Valid;
  logic [ALU_WIDTH-1:0] TXCont_ALU_Out;
  logic                 TXCont_ALU_Valid;
  logic                 TXCont_Busy;
  logic [7:0]           TXCont_Pdata;
  logic                 TXCont_Data_Valid;
  logic                 TXCont_Ready;
  logic                 TXCont_Overflow;

  modport slave (
    input  TXCont_RF_Rd_Data, TXCont_RF_Rd_Valid, TXCont_ALU_Out, TXCont_ALU_Valid, TXCont_Busy,
    output TXCont_Pdata, TXCont_Data_Valid, TXCont_Ready, TXCont_Overflow
  );

  modport master (
    output TXCont_RF_Rd_Data, TXCont_RF_Rd_Valid, TXCont_ALU_Out, TXCont_ALU_Valid, TXCont_Busy,
    input  TXCont_Pdata, TXCont_Data_Valid, TXCont_Ready, TXCont_Overflow
  );
endinterface

// File: rtl/tx_frame_slot_buf.sv
// Two-entry ACTIVE/PENDING frame buffer: capture, promotion on free, overflow detect.
// Strobes land in a slot at the next clock edge; Ready/Overflow are registered.
// No stall: a strobe that finds both slots full is dropped with an Overflow pulse.
module tx_frame_slot_buf
  import uart_sys_pkg::*;
#(
  parameter int ALU_WIDTH = 16
) (
  input  logic                 RXCont_CLK,
  input  logic                 RXCont_RST,
  input  logic                 i_rf_vld,
  input  logic [7:0]           i_rf_dat,
  input  logic                 i_alu_vld,
  input  logic [ALU_WIDTH-1:0] i_alu_dat,
  input  logic                 i_free,
  output logic                 o_act_vld,
  output frm_type_e            o_act_typ,
  output logic [ALU_WIDTH-1:0] o_act_pay,
  output logic                 o_pend_vld,
  output logic                 o_ready,
  output logic                 o_overflow
);

  logic                 r_act_vld, r_pnd_vld;
  frm_type_e            r_act_typ, r_pnd_typ;
  logic [ALU_WIDTH-1:0] r_act_pay, r_pnd_pay;
  logic                 r_ready, r_ovf;

  logic                 w_a_vld, w_p_vld, w_drop;
  frm_type_e            w_a_typ, w_p_typ;
  logic [ALU_WIDTH-1:0] w_a_pay, w_p_pay;

  // Next slot contents: promotion first, so a same-cycle strobe sees the freed PENDING slot
  always_comb begin
    w_a_vld = r_act_vld;
    w_a_typ = r_act_typ;
    w_a_pay = r_act_pay;
    w_p_vld = r_pnd_vld;
    w_p_typ = r_pnd_typ;
    w_p_pay = r_pnd_pay;
    w_drop  = 1'b0;
    if (i_free) begin
      w_a_vld = r_pnd_vld;
      w_a_typ = r_pnd_typ;
      w_a_pay = r_pnd_pay;
      w_p_vld = 1'b0;
    end
    // RF wins the first free slot when both strobes coincide
    if (i_rf_vld) begin
      if (!w_a_vld) begin
        w_a_vld = 1'b1;
        w_a_typ = FRM_RF;
        w_a_pay = ALU_WIDTH'(i_rf_dat);
      end else if (!w_p_vld) begin
        w_p_vld = 1'b1;
        w_p_typ = FRM_RF;
        w_p_pay = ALU_WIDTH'(i_rf_dat);
      end else begin
        w_drop = 1'b1;
      end
    end
    if (i_alu_vld) begin
      if (!w_a_vld) begin
        w_a_vld = 1'b1;
        w_a_typ = FRM_ALU;
        w_a_pay = i_alu_dat;
      end else if (!w_p_vld) begin
        w_p_vld = 1'b1;
        w_p_typ = FRM_ALU;
        w_p_pay = i_alu_dat;
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  // Slot registers plus registered Ready/Overflow flags
  always_ff @(posedge RXCont_CLK or negedge RXCont_RST) begin
    if (!RXCont_RST) begin
      r_act_vld <= 1'b0;
      r_act_typ <= FRM_RF;
      r_act_pay <= '0;
      r_pnd_vld <= 1'b0;
      r_pnd_typ <= FRM_RF;
      r_pnd_pay <= '0;
      r_ready   <= 1'b1;
      r_ovf     <= 1'b0;
    end else begin
      r_act_vld <= w_a_vld;
      r_act_typ <= w_a_typ;
      r_act_pay <= w_a_pay;
      r_pnd_vld <= w_p_vld;
      r_pnd_typ <= w_p_typ;
      r_pnd_pay <= w_p_pay;
      r_ready   <= !w_p_vld;
      r_ovf     <= w_drop;
    end
  end

  assign o_act_vld  = r_act_vld;
  assign o_act_typ  = r_act_typ;
  assign o_act_pay  = r_act_pay;
  assign o_pend_vld = r_pnd_vld;
  assign o_ready    = r_ready;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/tx_frame_controller.sv
// TX frame controller: serialises RF read data / ALU results into bytes for the UART TX.
// First Data_Valid two cycles after the strobe when idle; one SEND cycle after Busy drops per byte.
// Waits on TXCont_Busy per byte; two frames buffered, further strobes dropped (Overflow). Header byte: TX_FRAME_HEADER_EN.
module tx_frame_controller
  import uart_sys_pkg::*;
#(
  parameter int         ALU_WIDTH = 16,
  parameter logic [7:0] HDR_RF    = HDR_RF_DEF,
  parameter logic [7:0] HDR_ALU   = HDR_ALU_DEF
) (
  input logic                  RXCont_CLK,
  input logic                  RXCont_RST,
  tx_frame_controller_if.slave bus
);

`ifdef TX_FRAME_HEADER_EN
  localparam int HDR_N = 1;
`else
  localparam int HDR_N = 0;
`endif
  localparam int NBYTES  = ALU_WIDTH / 8;
  localparam int FRM_MAX = NBYTES + HDR_N;
  localparam int IDX_W   = (FRM_MAX > 1) ? $clog2(FRM_MAX) : 1;
  localparam logic [IDX_W-1:0] LAST_RF  = IDX_W'(HDR_N);
  localparam logic [IDX_W-1:0] LAST_ALU = IDX_W'(FRM_MAX - 1);

  logic [1:0]           r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [7:0]           r_pdata;
  logic                 r_dv;

  logic                 w_act_vld, w_pend_vld, w_ready, w_ovf, w_free;
  frm_type_e            w_act_typ;
  logic [ALU_WIDTH-1:0] w_act_pay;
  logic [IDX_W-1:0]     w_last, w_sel;
  logic [7:0]           w_byte;

  tx_frame_slot_buf #(
    .ALU_WIDTH(ALU_WIDTH)
  ) u_slot_buf (
    .RXCont_CLK (RXCont_CLK),
    .RXCont_RST (RXCont_RST),
    .i_rf_vld   (bus.TXCont_RF_Rd_Valid),
    .i_rf_dat   (bus.TXCont_RF_Rd_Data),
    .i_alu_vld  (bus.TXCont_ALU_Valid),
    .i_alu_dat  (bus.TXCont_ALU_Out),
    .i_free     (w_free),
    .o_act_vld  (w_act_vld),
    .o_act_typ  (w_act_typ),
    .o_act_pay  (w_act_pay),
    .o_pend_vld (w_pend_vld),
    .o_ready    (w_ready),
    .o_overflow (w_ovf)
  );

  assign w_last = (w_act_typ == FRM_ALU) ? LAST_ALU : LAST_RF;
  // ACTIVE is released on the cycle the last byte's Busy falls
  assign w_free = (r_state == ST_WAIT_DONE) && !bus.TXCont_Busy && (r_idx == w_last);

  // Current byte: optional header at index 0, then payload LSB first
  always_comb begin
`ifdef TX_FRAME_HEADER_EN
    w_sel  = r_idx - IDX_W'(1);
    w_byte = w_act_pay[{w_sel, 3'b000} +: 8];
    if (r_idx == '0) begin
      w_byte = (w_act_typ == FRM_ALU) ? HDR_ALU : HDR_RF;
    end
`else
    w_sel  = r_idx;
    w_byte = w_act_pay[{w_sel, 3'b000} +: 8];
`endif
  end

  // Byte handshake FSM; IDLE also reacts to a strobe being captured this cycle
  always_ff @(posedge RXCont_CLK or negedge RXCont_RST) begin
    if (!RXCont_RST) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_pdata <= 8'h00;
      r_dv    <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_act_vld || bus.TXCont_RF_Rd_Valid || bus.TXCont_ALU_Valid) begin
            r_idx   <= '0;
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!bus.TXCont_Busy) begin
            r_pdata <= w_byte;
            r_dv    <= 1'b1;
            r_state <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (bus.TXCont_Busy) begin
            r_state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!bus.TXCont_Busy) begin
            if (r_idx != w_last) begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_SEND;
            end else begin
              r_idx   <= '0;
              r_state <= w_pend_vld ? ST_SEND : ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.TXCont_Pdata      = r_pdata;
  assign bus.TXCont_Data_Valid = r_dv;
  assign bus.TXCont_Ready      = w_ready;
  assign bus.TXCont_Overflow   = w_ovf;

endmodule

// File: tb/tb_tx_frame_controller.sv
// Bench for tx_frame_controller: directed strobes, UART TX Busy model,
// scoreboard queue of expected bytes checked by an independent monitor.
module tb_tx_frame_controller;
  import uart_sys_pkg::*;

  localparam int AW = 16;
`ifdef TX_FRAME_HEADER_EN
  localparam int HN = 1;
`else
  localparam int HN = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tx_frame_controller_if #(.ALU_WIDTH(AW)) bus();

  tx_frame_controller #(
    .ALU_WIDTH(AW),
    .HDR_RF   (8'h5A),
    .HDR_ALU  (8'hA5)
  ) dut (
    .RXCont_CLK(clk),
    .RXCont_RST(rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int pop_cnt = 0;
  int ovf_cnt = 0;
  bit busy_auto = 1'b1;
  int busy_len = 3;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push_rf(input logic [7:0] d);
    if (HN == 1) exp_q.push_back(8'h5A);
    exp_q.push_back(d);
  endtask

  task automatic push_alu(input logic [15:0] v);
    if (HN == 1) exp_q.push_back(8'hA5);
    exp_q.push_back(v[7:0]);
    exp_q.push_back(v[15:8]);
  endtask

  // One-cycle strobe; returns #1 after the capture edge
  task automatic strobe(input bit rv, input logic [7:0] rd, input bit av, input logic [15:0] ad);
    @(posedge clk); #1;
    bus.TXCont_RF_Rd_Valid = rv;
    bus.TXCont_RF_Rd_Data  = rd;
    bus.TXCont_ALU_Valid   = av;
    bus.TXCont_ALU_Out     = ad;
    @(posedge clk); #1;
    bus.TXCont_RF_Rd_Valid = 1'b0;
    bus.TXCont_ALU_Valid   = 1'b0;
  endtask

  task automatic wait_dv(input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.TXCont_Data_Valid && t < 200);
    if (!bus.TXCont_Data_Valid) begin
      n_chk++;
      $display("FAIL %s: no Data_Valid within 200 cycles, required one", nm);
    end
  endtask

  // All expected bytes seen, then let the last Busy pulse run out
  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL %s: %0d bytes still outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (busy_len + 4) @(negedge clk);
  endtask

  // Scoreboard monitor
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.TXCont_Overflow) ovf_cnt++;
      if (bus.TXCont_Data_Valid) begin
        chk("busy_low_at_req", bus.TXCont_Busy, 0);
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.TXCont_Pdata);
        end else begin
          e = exp_q.pop_front();
          pop_cnt++;
          chk("byte", bus.TXCont_Pdata, e);
        end
      end
    end
  end

  // UART TX model: Busy rises one cycle after the request, holds busy_len cycles
  initial begin
    forever begin
      @(posedge clk); #1;
      if (busy_auto && bus.TXCont_Data_Valid) begin
        @(posedge clk); #1;
        bus.TXCont_Busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 bus.TXCont_Busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bus.TXCont_RF_Rd_Valid = 1'b0;
    bus.TXCont_RF_Rd_Data  = 8'h00;
    bus.TXCont_ALU_Valid   = 1'b0;
    bus.TXCont_ALU_Out     = '0;
    bus.TXCont_Busy        = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pdata", bus.TXCont_Pdata, 0);
    chk("rst_dv", bus.TXCont_Data_Valid, 0);
    chk("rst_ready", bus.TXCont_Ready, 1);
    chk("rst_ovf", bus.TXCont_Overflow, 0);
    rst_n = 1'b1;

    // RF 3C: Data_Valid at N+2, long Busy, back to IDLE
    busy_len = 10;
    push_rf(8'h3C);
    strobe(1'b1, 8'h3C, 1'b0, 16'h0);
    @(posedge clk); #1;
    chk("latency_n2", bus.TXCont_Data_Valid, 1);
    wait_done("rf_3c");
    chk("idle_after_rf", dut.r_state, ST_IDLE);
    busy_len = 3;

    // ALU BEEF: EF then BE
    push_alu(16'hBEEF);
    strobe(1'b0, 8'h00, 1'b1, 16'hBEEF);
    wait_done("alu_beef");

    // Simultaneous RF 11 + ALU 1234
    base = pop_cnt;
    push_rf(8'h11);
    push_alu(16'h1234);
    strobe(1'b1, 8'h11, 1'b1, 16'h1234);
    chk("ready_low_pend", bus.TXCont_Ready, 0);
    wait_dv("both_first");
    chk("ready_low_first_byte", bus.TXCont_Ready, 0);
    begin
      int t;
      t = 0;
      while (!bus.TXCont_Ready && t < 200) begin
        @(negedge clk);
        t++;
      end
    end
    chk("ready_rise_after_rf", pop_cnt - base, 1 + HN);
    wait_done("both");

    // Third strobe dropped while first byte in flight
    base = ovf_cnt;
    push_alu(16'h5566);
    strobe(1'b0, 8'h00, 1'b1, 16'h5566);
    wait_dv("ovf_first");
    push_rf(8'h77);
    strobe(1'b1, 8'h77, 1'b0, 16'h0);
    chk("ready_low_full", bus.TXCont_Ready, 0);
    strobe(1'b1, 8'h88, 1'b0, 16'h0);
    wait_done("ovf");
    chk("ovf_single_pulse", ovf_cnt - base, 1);

    // Reset while waiting for Busy to fall after the first ALU byte
    busy_auto = 1'b0;
    exp_q.push_back((HN == 1) ? 8'hA5 : 8'hCD);
    strobe(1'b0, 8'h00, 1'b1, 16'hABCD);
    wait_dv("rst_first");
    @(posedge clk); #1 bus.TXCont_Busy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_wait_done", dut.r_state, ST_WAIT_DONE);
    rst_n = 1'b0;
    #1;
    chk("midrst_pdata", bus.TXCont_Pdata, 0);
    chk("midrst_ready", bus.TXCont_Ready, 1);
    chk("midrst_dv", bus.TXCont_Data_Valid, 0);
    chk("midrst_state", dut.r_state, ST_IDLE);
    bus.TXCont_Busy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_ready", bus.TXCont_Ready, 1);
    chk("post_rst_queue", exp_q.size(), 0);
    busy_auto = 1'b1;

    // Header reference vectors (headers expected only when enabled)
    push_rf(8'h07);
    strobe(1'b1, 8'h07, 1'b0, 16'h0);
    wait_done("rf_07");
    push_alu(16'h0102);
    strobe(1'b0, 8'h00, 1'b1, 16'h0102);
    wait_done("alu_0102");

    chk("total_ovf", ovf_cnt, 1);
    chk("final_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
